// File: rtl/ucsbece152a_counter_checker_if.sv
// Purpose: bundles the observed-counter stimulus and the checker status outputs.
// Latency: none, wiring only.
// Backpressure: none; the checker observes every cycle.
interface ucsbece152a_counter_checker_if #(
    parameter int WIDTH = 3,
    parameter int ERRW  = 8
);
    logic             ctr_rst_i;
    logic             enable_i;
    logic             dir_i;
    logic [WIDTH-1:0] count_i;
    logic             check_en_i;
    logic             locked_o;
    logic             mismatch_o;
    logic             sticky_err_o;
    logic [ERRW-1:0]  err_count_o;
    logic [WIDTH-1:0] expected_o;

    // Side that drives the counter under observation.
    modport master (
        output ctr_rst_i, enable_i, dir_i, count_i, check_en_i,
        input  locked_o, mismatch_o, sticky_err_o, err_count_o, expected_o
    );

    // The checker itself.
    modport slave (
        input  ctr_rst_i, enable_i, dir_i, count_i, check_en_i,
        output locked_o, mismatch_o, sticky_err_o, err_count_o, expected_o
    );
endinterface

// File: rtl/ucsbece152a_counter_checker.sv
// Purpose: predicts an up/down counter's next value from its previous controls and flags deviations.
// Latency: mismatch/expected/error status appear one cycle after the checked sample.
// Backpressure: none; a sample is taken on every clock edge.
module ucsbece152a_counter_checker #(
    parameter int WIDTH = 3,
    parameter int ERRW  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    ucsbece152a_counter_checker_if.slave         bus
);
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERRW-1:0]  ERR_ONE = {{(ERRW-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] prev_count;
    logic             prev_ctr_rst;
    logic             prev_enable;
    logic             prev_dir;
    logic [WIDTH-1:0] predicted;
    logic             check_now;
    logic             miss_now;

    logic             locked_q;
    logic             mismatch_q;
    logic             sticky_q;
    logic [ERRW-1:0]  err_count_q;
    logic [WIDTH-1:0] expected_q;

    // Next-value prediction from last cycle's observed value and controls; wraps naturally.
    always_comb begin
        predicted = prev_count;
        if (prev_ctr_rst) begin
            predicted = '0;
        end else if (prev_enable) begin
            predicted = prev_dir ? (prev_count - CNT_ONE) : (prev_count + CNT_ONE);
        end
    end

    // A check happens only when already locked and checking stays enabled this edge.
    always_comb begin
        check_now = (state == LOCKED) && bus.check_en_i;
        miss_now  = check_now && (bus.count_i != predicted);
    end

    // Lock FSM with registered status outputs; prev_* always follow the raw inputs so a
    // mismatch resynchronises to what the counter actually did.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= UNLOCKED;
            locked_q     <= 1'b0;
            mismatch_q   <= 1'b0;
            sticky_q     <= 1'b0;
            err_count_q  <= '0;
            expected_q   <= '0;
            prev_count   <= '0;
            prev_ctr_rst <= 1'b0;
            prev_enable  <= 1'b0;
            prev_dir     <= 1'b0;
        end else begin
            prev_count   <= bus.count_i;
            prev_ctr_rst <= bus.ctr_rst_i;
            prev_enable  <= bus.enable_i;
            prev_dir     <= bus.dir_i;
            mismatch_q   <= miss_now;

            case (state)
                UNLOCKED: begin
                    // This sample only seeds prev_*; nothing to compare against yet.
                    if (bus.check_en_i) begin
                        state    <= LOCKED;
                        locked_q <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (!bus.check_en_i) begin
                        state    <= UNLOCKED;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= UNLOCKED;
                    locked_q <= 1'b0;
                end
            endcase

            if (check_now) begin
                expected_q <= predicted;
            end

            if (miss_now) begin
                sticky_q <= 1'b1;
                if (err_count_q != {ERRW{1'b1}}) begin
                    err_count_q <= err_count_q + ERR_ONE;
                end
            end
        end
    end

    assign bus.locked_o     = locked_q;
    assign bus.mismatch_o   = mismatch_q;
    assign bus.sticky_err_o = sticky_q;
    assign bus.err_count_o  = err_count_q;
    assign bus.expected_o   = expected_q;
endmodule

// File: doc/ucsbece152a_counter_checker.md
UCSBECE152A_COUNTER_CHECKER -- requirements
Module: ucsbece152a_counter_checker

Interface
REQ-001 Parameter WIDTH, default 3: width of the observed counter value.
REQ-002 Parameter ERRW, default 8: width of the error counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  checker reset; synchronous, active-high.
REQ-005 ctr_rst_i  input  1  reset applied to the observed counter in this cycle.
REQ-006 enable_i  input  1  enable applied to the observed counter in this cycle.
REQ-007 dir_i  input  1  direction applied to the observed counter in this cycle: 0 = up, 1 = down.
REQ-008 count_i  input  WIDTH  observed counter output, sampled at posedge clk.
REQ-009 check_en_i  input  1  1 = checking active; 0 = drop lock, perform no checks.
REQ-010 locked_o  output  1  1 = checker in LOCKED state.
REQ-011 mismatch_o  output  1  one-cycle pulse per detected mismatch.
REQ-012 sticky_err_o  output  1  set on the first mismatch; held until rst.
REQ-013 err_count_o  output  ERRW  saturating count of mismatches.
REQ-014 expected_o  output  WIDTH  registered predicted value used in the most recent check.

Function
REQ-015 The checker SHALL register count_i, ctr_rst_i, enable_i and dir_i every cycle as prev_* values.
REQ-016 Prediction rule, mod 2^WIDTH: prev_ctr_rst=1 -> 0; else prev_enable=0 -> prev_count; else prev_dir=0 -> prev_count+1; else prev_count-1.
REQ-017 Increment and decrement SHALL wrap: 2^WIDTH-1 +1 -> 0, and 0 -1 -> 2^WIDTH-1.
REQ-018 The FSM SHALL have exactly two states, UNLOCKED and LOCKED; the reset state is UNLOCKED.
REQ-019 UNLOCKED -> LOCKED on a posedge with check_en_i=1; that sample SHALL only seed prev_* and SHALL NOT be checked.
REQ-020 LOCKED -> UNLOCKED on any posedge with check_en_i=0; no check SHALL occur on that cycle.
REQ-021 In LOCKED with check_en_i=1, each posedge SHALL compare count_i against the REQ-016 prediction.
REQ-022 On a mismatch, mismatch_o SHALL be 1 for exactly the following cycle (registered, latency 1).
REQ-023 On a mismatch, sticky_err_o SHALL be set, and err_count_o SHALL increment unless it is all ones (saturate, no wrap).
REQ-024 After a mismatch the checker SHALL resynchronise: later predictions derive from the observed count_i, so one fault yields one mismatch.
REQ-025 expected_o SHALL update only on checked cycles and hold its value otherwise.
REQ-026 A sample with ctr_rst_i=1 SHALL itself be checked normally; it affects only the next prediction.
REQ-027 locked_o SHALL equal (state == LOCKED), registered.

Reset
REQ-028 With rst=1 at posedge: state=UNLOCKED, locked_o=0, mismatch_o=0, sticky_err_o=0, err_count_o=0, expected_o=0, all prev_*=0.
REQ-029 Reset SHALL take priority over every other input, including mid-LOCKED and on a mismatch cycle; that cycle's check SHALL be discarded.
REQ-030 The first checkable sample after rst deasserts SHALL be the second posedge with check_en_i=1 (REQ-019).

Verification (WIDTH=3, ERRW=8)
REQ-031 Up count: check_en=1, enable=1, dir=0, count_i 0..7,0..7 over 16 cycles -> mismatch_o never 1, err_count_o=0, locked_o=1 from cycle 2.
REQ-032 Down wrap plus hold: count_i 2,1,0,7,6, then enable=0 for 3 cycles with count_i held at 6 -> no mismatch.
REQ-033 Injected fault: expected 4, count_i=5 -> mismatch_o=1 for one cycle, expected_o=4, sticky=1, err_count_o=1; next 6 is accepted (resync).
REQ-034 Counter reset: ctr_rst_i=1 while count_i=5; next count_i=0 -> no mismatch; next count_i=6 instead -> mismatch, expected_o=0.
REQ-035 Saturation plus rst: force 260 mismatches -> err_count_o=255 and held; assert rst -> all outputs 0, locked_o=0.
REQ-036 check_en drop: check_en_i=0 for 2 cycles with garbage count_i -> no mismatch, locked_o=0; re-enable -> first sample seeds, second is checked.
